serial_sub: RTL and testbench

Parametrised bit-serial subtractor: computes D = A − B − Bin over WIDTH bits. It processes one bit per clock through a single full-subtractor slice and a registered borrow. It trades the combinational ripple-borrow chain for WIDTH cycles of latency and a start/busy/done handshake. It sits in the arithmetic datapath wherever wide operands must be subtracted with minimal logic.

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/serial_sub_fs_cell.sv | 14 +
 rtl/serial_sub.sv | 137 +++++++++++++
 tb/tb_serial_sub.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the supported operand width range.
package serial_sub_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_fs_cell.sv
// Combinational full-subtractor bit slice: d = a - b - bin, bout = borrow out.
// Shared by the serial arithmetic blocks.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("serial_sub: WIDTH out of supported range");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             w_diff;
    logic             w_nbr;
    logic             w_accept;
    logic             w_last;

    fs_cell u_fs_cell (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_br),
        .d    (w_diff),
        .bout (w_nbr)
    );

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == LAST) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = start ? SHIFT : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_sa doubles as the result shift register: each diff bit enters at the
    // MSB as the consumed minuend bit leaves at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_d    <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_sa  <= a;
            r_sb  <= b;
            r_br  <= bin;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_sa <= {w_diff, r_sa[WIDTH-1:1]};
            r_sb <= r_sb >> 1;
            r_br <= w_nbr;
            if (w_last) begin
                r_d    <= {w_diff, r_sa[WIDTH-1:1]};
                r_bout <= w_nbr;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Operand sign bits are shifted out of r_sa/r_sb, so keep copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (w_last) begin
            r_ovf <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`endif

    assign d         = r_d;
    assign bout      = r_bout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: an 8-bit instance for latency, busy and
// reset scenarios, and a 4-bit instance for exhaustive back-to-back operation.
`timescale 1ns/1ps
module tb_serial_sub;
    import serial_sub_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] d8;
    logic [1:0] st8;

    logic       s4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] d4;
    logic [1:0] st4;

`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf4;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s8),
        .a         (a8),
        .b         (b8),
        .bin       (bin8),
        .busy      (busy8),
        .done      (done8),
        .d         (d8),
        .bout      (bout8),
`ifdef SERIAL_SUB_OVF_EN
        .ovf       (ovf8),
`endif
        .dbg_state (st8)
    );

    serial_sub #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s4),
        .a         (a4),
        .b         (b4),
        .bin       (bin4),
        .busy      (busy4),
        .done      (done4),
        .d         (d4),
        .bout      (bout4),
`ifdef SERIAL_SUB_OVF_EN
        .ovf       (ovf4),
`endif
        .dbg_state (st4)
    );

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, bout8} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags busy/done/bout got %b want 000", {busy8, done8, bout8});
        end
        checks++;
        if (d8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_d got %h want 00", d8);
        end
        checks++;
        if (st8 !== IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d want %0d", st8, IDLE);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", ovf8);
        end
`endif
        rst_n = 1'b1;
    endtask

    // One 8-bit operation; ign_at > 0 pulses start with junk operands that many cycles into SHIFT.
    task automatic run8(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tbin, input logic [7:0] ed, input logic eb,
                        input logic eo, input int ign_at);
        int n;
        s8 = 1'b1; a8 = ta; b8 = tb_v; bin8 = tbin;
        @(posedge clk); #1;
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept got %b want 1", name, busy8);
        end
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            if (ign_at > 0 && n == ign_at) begin
                s8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
            end else begin
                s8 = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        s8 = 1'b0;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL %s latency got %0d want 8", name, n);
        end
        checks++;
        if ({bout8, d8} !== {eb, ed}) begin
            errors++;
            $display("FAIL %s result got bout=%b d=%h want bout=%b d=%h", name, bout8, d8, eb, ed);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf8 !== eo) begin
            errors++;
            $display("FAIL %s ovf got %b want %b", name, ovf8, eo);
        end
`else
        if (eo === 1'bx) $display("unexpected ovf expectation in %s", name);
`endif
        @(posedge clk); #1;
        checks++;
        if ({done8, busy8} !== 2'b00 || st8 !== IDLE) begin
            errors++;
            $display("FAIL %s after_done done=%b busy=%b state=%0d want 0 0 %0d", name, done8, busy8, st8, IDLE);
        end
    endtask

    task automatic test_basic();
        run8("sub_05_03",    8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);
        run8("sub_03_05",    8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);
        run8("sub_00_00_b",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        run8("sub_80_01",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
        run8("sub_ff_ff_b",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        run8("sub_7f_80",    8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 0);
        run8("sub_a5_5a",    8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 0);
        run8("sub_10_0f_b",  8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic test_busy_ignore();
        run8("busy_ignore", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 3);
    endtask

    task automatic test_reset_mid();
        int seen;
        s8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, bout8, d8} !== 11'h000 || st8 !== IDLE) begin
            errors++;
            $display("FAIL reset_mid outputs busy=%b done=%b bout=%b d=%h state=%0d want all 0",
                     busy8, done8, bout8, d8, st8);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ovf got %b want 0", ovf8);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || d8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_no_done activity_cycles=%0d d=%h want 0 and 00", seen, d8);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [3:0] ta, tb_v;
        logic tbin;
        logic [4:0] e;
        s4 = 1'b1;
        for (int k = 0; k < 512; k++) begin
            ta   = 4'(k >> 5);
            tb_v = 4'(k >> 1);
            tbin = k[0];
            a4 = ta; b4 = tb_v; bin4 = tbin;
            e = {1'b0, ta} - {1'b0, tb_v} - {4'b0000, tbin};
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (done4 !== 1'b1 && n < 12);
            if (k == 511) s4 = 1'b0;
            checks++;
            if (n != 5) begin
                errors++;
                $display("FAIL b2b_spacing op=%0d got %0d want 5", k, n);
            end
            checks++;
            if ({bout4, d4} !== e) begin
                errors++;
                $display("FAIL b2b_result a=%h b=%h bin=%b got bout=%b d=%h want bout=%b d=%h",
                         ta, tb_v, tbin, bout4, d4, e[4], e[3:0]);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ovf4 !== ((ta[3] != tb_v[3]) && (e[3] != ta[3]))) begin
                errors++;
                $display("FAIL b2b_ovf a=%h b=%h bin=%b got %b", ta, tb_v, tbin, ovf4);
            end
`endif
        end
        s4 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (st4 !== IDLE || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end state=%0d busy=%b want %0d 0", st4, busy4, IDLE);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
